instr_field_pipe: RTL and testbench

Registered, parametrised MIPS instruction field splitter sitting between instruction fetch and decode. It accepts a 32-bit instruction word plus its PC over a valid/ready handshake. It splits the word into all R/I/J fields, computes the extended immediate and jump address, and presents them on a registered output stage. A two-entry skid buffer gives full throughput with backpressure, and a flush input supports branch/jump squash.

---
 rtl/instr_field_pipe.sv | 179 +++++++++++++++++
 tb/tb_instr_field_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_field_pipe.sv
// instr_field_pipe: registered MIPS instruction field splitter between fetch
// and decode. The raw word is decoded combinationally in front of the output
// register, so the output stage always holds finished fields. A two-entry
// buffer (output register + skid register) keeps full throughput under
// backpressure, and flush squashes everything that is held or arriving.
//
// Handshake: a beat moves on a port in any cycle where valid and ready are
// both 1 at the rising edge. A producer holds valid and data steady until
// the beat moves. in_ready comes straight from a register (~skid_valid), and
// out_valid/payload stay put while out_ready is low.
module instr_field_pipe #(
  parameter int PC_W       = 32,
  parameter int EXT_W      = 32,
  parameter bit ZEXT_LOGIC = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_opcode,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [5:0]       out_funct,
  output logic [15:0]      out_imm,
  output logic [25:0]      out_target,
  output logic             out_bgez,
  output logic [EXT_W-1:0] out_imm_ext,
  output logic [PC_W-1:0]  out_jaddr,
  output logic [PC_W-1:0]  out_pc
);

  // Holding state
  logic              r_out_valid;
  logic              r_skid_valid;
  logic [31:0]       r_skid_instr;
  logic [PC_W-1:0]   r_skid_pc;

  // Output payload registers
  logic [5:0]        r_opcode;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [4:0]        r_shamt;
  logic [5:0]        r_funct;
  logic [15:0]       r_imm;
  logic [25:0]       r_target;
  logic              r_bgez;
  logic [EXT_W-1:0]  r_imm_ext;
  logic [PC_W-1:0]   r_jaddr;
  logic [PC_W-1:0]   r_pc;

  // Handshake and steering
  logic              w_accept;
  logic              w_out_free;
  logic              w_load_out;
  logic              w_load_skid;

  // Decode path
  logic [31:0]       w_src_instr;
  logic [PC_W-1:0]   w_src_pc;
  logic [5:0]        w_opcode;
  logic [15:0]       w_imm;
  logic              w_zext;
  logic [EXT_W-1:0]  w_imm_ext;
  logic [PC_W-1:0]   w_jaddr;

  assign in_ready   = ~r_skid_valid;
  assign w_accept   = in_valid & ~r_skid_valid;
  // Output register can take a new beat: it is empty or draining this cycle.
  assign w_out_free = ~r_out_valid | out_ready;
  // Output loads from skid if it holds something, else from an accepted beat.
  assign w_load_out  = ~flush & w_out_free & (r_skid_valid | w_accept);
  // New beat parks in skid when the output is blocked, or when the skid is
  // being drained into the output in the same cycle.
  assign w_load_skid = ~flush & w_accept & (r_skid_valid | ~w_out_free);

  // Oldest beat wins the decode path: skid content ahead of the input port.
  assign w_src_instr = r_skid_valid ? r_skid_instr : in_instr;
  assign w_src_pc    = r_skid_valid ? r_skid_pc    : in_pc;
  assign w_opcode    = w_src_instr[31:26];
  assign w_imm       = w_src_instr[15:0];
  assign w_zext      = ZEXT_LOGIC && ((w_opcode == 6'h0C) || (w_opcode == 6'h0D) ||
                                      (w_opcode == 6'h0E));

  // Immediate extension: zero-extend logical ops when enabled, else sign-extend.
  always_comb begin
    w_imm_ext       = '0;
    w_imm_ext[15:0] = w_imm;
    for (int b = 16; b < EXT_W; b++) begin
      w_imm_ext[b] = w_zext ? 1'b0 : w_imm[15];
    end
  end

  // Jump address: upper PC bits kept, low 28 bits from target word-aligned.
  always_comb begin
    w_jaddr       = w_src_pc;
    w_jaddr[27:0] = {w_src_instr[25:0], 2'b00};
  end

  // Valid bits for the output register and skid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      r_out_valid  <= r_skid_valid | w_accept;
      r_skid_valid <= r_skid_valid & w_accept;
    end else begin
      r_skid_valid <= r_skid_valid | w_accept;
    end
  end

  // Skid register keeps the raw word and PC; decode happens on the way out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else if (w_load_skid) begin
      r_skid_instr <= in_instr;
      r_skid_pc    <= in_pc;
    end
  end

  // Output payload captures the fully decoded fields of the selected beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode  <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_shamt   <= '0;
      r_funct   <= '0;
      r_imm     <= '0;
      r_target  <= '0;
      r_bgez    <= 1'b0;
      r_imm_ext <= '0;
      r_jaddr   <= '0;
      r_pc      <= '0;
    end else if (w_load_out) begin
      r_opcode  <= w_opcode;
      r_rs      <= w_src_instr[25:21];
      r_rt      <= w_src_instr[20:16];
      r_rd      <= w_src_instr[15:11];
      r_shamt   <= w_src_instr[10:6];
      r_funct   <= w_src_instr[5:0];
      r_imm     <= w_imm;
      r_target  <= w_src_instr[25:0];
      r_bgez    <= w_src_instr[20];
      r_imm_ext <= w_imm_ext;
      r_jaddr   <= w_jaddr;
      r_pc      <= w_src_pc;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_opcode  = r_opcode;
  assign out_rs      = r_rs;
  assign out_rt      = r_rt;
  assign out_rd      = r_rd;
  assign out_shamt   = r_shamt;
  assign out_funct   = r_funct;
  assign out_imm     = r_imm;
  assign out_target  = r_target;
  assign out_bgez    = r_bgez;
  assign out_imm_ext = r_imm_ext;
  assign out_jaddr   = r_jaddr;
  assign out_pc      = r_pc;

endmodule

// File: tb/tb_instr_field_pipe.sv
// Bench for instr_field_pipe: fixed decode vectors, a randomized stream under
// random backpressure against a queue-based reference, then flush and
// mid-stall reset sequences. A second instance with ZEXT_LOGIC=0 shares all
// inputs so both extension modes are seen on every beat.
module tb_instr_field_pipe;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        bgez;
    logic [31:0] imm_ext;
    logic [31:0] jaddr;
    logic [31:0] pc;
  } fields_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    fields_t     exp;
    logic [31:0] ext0;
  } vec_t;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm;
  logic [25:0] out_target;
  logic        out_bgez;
  logic [31:0] out_imm_ext, out_jaddr, out_pc;

  logic        in_ready_z, out_valid_z;
  logic [5:0]  out_opcode_z;
  logic [4:0]  out_rs_z, out_rt_z, out_rd_z, out_shamt_z;
  logic [5:0]  out_funct_z;
  logic [15:0] out_imm_z;
  logic [25:0] out_target_z;
  logic        out_bgez_z;
  logic [31:0] out_imm_ext_z, out_jaddr_z, out_pc_z;

  always #5 clk = ~clk;

  instr_field_pipe #(.PC_W(32), .EXT_W(32), .ZEXT_LOGIC(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm),
    .out_target(out_target), .out_bgez(out_bgez), .out_imm_ext(out_imm_ext),
    .out_jaddr(out_jaddr), .out_pc(out_pc)
  );

  instr_field_pipe #(.PC_W(32), .EXT_W(32), .ZEXT_LOGIC(1'b0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_z), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid_z), .out_ready(out_ready),
    .out_opcode(out_opcode_z), .out_rs(out_rs_z), .out_rt(out_rt_z), .out_rd(out_rd_z),
    .out_shamt(out_shamt_z), .out_funct(out_funct_z), .out_imm(out_imm_z),
    .out_target(out_target_z), .out_bgez(out_bgez_z), .out_imm_ext(out_imm_ext_z),
    .out_jaddr(out_jaddr_z), .out_pc(out_pc_z)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];   // {pc, instr} of beats held inside the DUT, oldest first

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the field definitions, using plain arithmetic.
  function automatic fields_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                         input bit zext);
    fields_t f;
    longint unsigned lw, lp, imm, ext;
    lw = 64'(w);
    lp = 64'(pc);
    f.opcode = 6'(lw / (64'd1 << 26));
    f.rs     = 5'((lw / (64'd1 << 21)) % 32);
    f.rt     = 5'((lw / (64'd1 << 16)) % 32);
    f.rd     = 5'((lw / (64'd1 << 11)) % 32);
    f.shamt  = 5'((lw / 64) % 32);
    f.funct  = 6'(lw % 64);
    imm      = lw % 65536;
    f.imm    = 16'(imm);
    f.target = 26'(lw % (64'd1 << 26));
    f.bgez   = 1'((lw / (64'd1 << 20)) % 2);
    if (zext && (f.opcode == 6'd12 || f.opcode == 6'd13 || f.opcode == 6'd14))
      ext = imm;
    else if (imm >= 32768)
      ext = imm + 64'hFFFF_0000;
    else
      ext = imm;
    f.imm_ext = 32'(ext);
    f.jaddr   = 32'((lp / (64'd1 << 28)) * (64'd1 << 28) + (lw % (64'd1 << 26)) * 4);
    f.pc      = pc;
    return f;
  endfunction

  task automatic check_fields(input string tag, input fields_t e);
    chk({tag, "_opcode"},  64'(out_opcode),  64'(e.opcode));
    chk({tag, "_rs"},      64'(out_rs),      64'(e.rs));
    chk({tag, "_rt"},      64'(out_rt),      64'(e.rt));
    chk({tag, "_rd"},      64'(out_rd),      64'(e.rd));
    chk({tag, "_shamt"},   64'(out_shamt),   64'(e.shamt));
    chk({tag, "_funct"},   64'(out_funct),   64'(e.funct));
    chk({tag, "_imm"},     64'(out_imm),     64'(e.imm));
    chk({tag, "_target"},  64'(out_target),  64'(e.target));
    chk({tag, "_bgez"},    64'(out_bgez),    64'(e.bgez));
    chk({tag, "_imm_ext"}, 64'(out_imm_ext), 64'(e.imm_ext));
    chk({tag, "_jaddr"},   64'(out_jaddr),   64'(e.jaddr));
    chk({tag, "_pc"},      64'(out_pc),      64'(e.pc));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b1;
  endtask

  task automatic drive_beat(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    vec_t    vecs[6];
    fields_t zero_f;
    fields_t e;
    logic [31:0] ins, pcs;
    int      sent;
    bit      acc, xfer, last_acc, done;

    zero_f = '0;
    // Hand-derived expectations: {instr, pc, fields (ZEXT=1), imm_ext with ZEXT=0}
    vecs[0] = '{32'h2408FFFF, 32'h00400004,
                '{6'h09, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h008FFFF, 1'b0,
                  32'hFFFFFFFF, 32'h0023FFFC, 32'h00400004}, 32'hFFFFFFFF};
    vecs[1] = '{32'h3508FFFF, 32'h00400008,
                '{6'h0D, 5'd8, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h108FFFF, 1'b0,
                  32'h0000FFFF, 32'h0423FFFC, 32'h00400008}, 32'hFFFFFFFF};
    vecs[2] = '{32'h08100003, 32'h90000004,
                '{6'h02, 5'd0, 5'd16, 5'd0, 5'd0, 6'h03, 16'h0003, 26'h0100003, 1'b1,
                  32'h00000003, 32'h9040000C, 32'h90000004}, 32'h00000003};
    vecs[3] = '{32'h01095020, 32'h00400010,
                '{6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h5020, 26'h1095020, 1'b0,
                  32'h00005020, 32'h04254080, 32'h00400010}, 32'h00005020};
    vecs[4] = '{32'h39288000, 32'h00400014,
                '{6'h0E, 5'd9, 5'd8, 5'd16, 5'd0, 6'h00, 16'h8000, 26'h1288000, 1'b0,
                  32'h00008000, 32'h04A20000, 32'h00400014}, 32'hFFFF8000};
    vecs[5] = '{32'h30008001, 32'hF0000004,
                '{6'h0C, 5'd0, 5'd0, 5'd16, 5'd0, 6'h01, 16'h8001, 26'h0008001, 1'b0,
                  32'h00008001, 32'hF0020004, 32'hF0000004}, 32'hFFFF8001};

    // Reset state
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    check_fields("rst", zero_f);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Table-driven decode vectors, back to back with out_ready=1
    for (int i = 0; i < 6; i++) begin
      drive_beat(vecs[i].instr, vecs[i].pc);
      @(negedge clk);
      chk("vec_out_valid", 64'(out_valid), 64'd1);
      check_fields($sformatf("vec%0d", i), vecs[i].exp);
      chk($sformatf("vec%0d_ext_z", i), 64'(out_imm_ext_z), 64'(vecs[i].ext0));
    end
    drive_idle();
    @(negedge clk);
    chk("vec_drain_valid", 64'(out_valid), 64'd0);

    // Randomized stream under random backpressure (first 8 words are 1..8)
    sent     = 0;
    last_acc = 1'b0;
    done     = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      chk("stream_in_ready",  64'(in_ready),  64'(exp_q.size() < 2));
      chk("stream_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        e = ref_decode(exp_q[0][31:0], exp_q[0][63:32], 1'b1);
        check_fields("stream", e);
        e = ref_decode(exp_q[0][31:0], exp_q[0][63:32], 1'b0);
        chk("stream_ext_z", 64'(out_imm_ext_z), 64'(e.imm_ext));
      end
      if (sent == 300 && exp_q.size() == 0) begin
        done = 1'b1;
      end else begin
        if (!(in_valid && !last_acc)) begin
          if (sent < 300 && $urandom_range(0, 3) != 0) begin
            ins = (sent < 8) ? 32'(sent + 1) : $urandom();
            pcs = $urandom();
            drive_beat(ins, pcs);
          end else begin
            in_valid = 1'b0;
          end
        end
        out_ready = ($urandom_range(0, 2) != 0) || (sent == 300);
        acc  = in_valid && (exp_q.size() < 2);
        xfer = out_valid && out_ready;
        if (xfer) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back({in_pc, in_instr});
          sent++;
        end
        last_acc = acc;
        @(negedge clk);
      end
    end
    chk("stream_completed", 64'(done), 64'd1);
    drive_idle();
    @(negedge clk);

    // Flush with skid full and a beat presented during the flush
    out_ready = 1'b0;
    drive_beat(32'h11111111, 32'h00001000);
    @(negedge clk);
    chk("fl_a_valid", 64'(out_valid), 64'd1);
    drive_beat(32'h22222222, 32'h00001004);
    @(negedge clk);
    chk("fl_skid_full_ready", 64'(in_ready), 64'd0);
    chk("fl_stall_pc", 64'(out_pc), 64'h00001000);
    drive_beat(32'h33333333, 32'h00001008);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_no_ghost", 64'(out_valid), 64'd0);
    end

    // Flush with empty pipe while a beat is accepted
    drive_beat(32'h44444444, 32'h0000100C);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_empty_valid", 64'(out_valid), 64'd0);
    drive_idle();
    @(negedge clk);
    chk("fl_empty_after", 64'(out_valid), 64'd0);

    // Async reset pulse in the middle of a full stall
    out_ready = 1'b0;
    drive_beat(32'h2408FFFF, 32'h90000004);
    @(negedge clk);
    drive_beat(32'h08100003, 32'h90000008);
    @(negedge clk);
    chk("rs_stall_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_valid", 64'(out_valid), 64'd0);
    chk("rs_async_ready", 64'(in_ready),  64'd1);
    check_fields("rs_async", zero_f);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rs_after_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
